// File: rtl/sb_pkg.sv
// Shared types for the store buffer: drain FSM states, pending-store entry and byte-merge helper.
package sb_pkg;

    // Word-address field width; sized for the widest supported AW.
    localparam int unsigned SB_WADDR_MAX = 62;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        WRITE = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic [SB_WADDR_MAX-1:0] waddr;
        logic [31:0]             data;
        logic [3:0]              be;
    } sb_entry_t;

    function automatic logic [31:0] sb_merge(input logic [31:0] data,
                                             input logic [3:0]  be,
                                             input logic [31:0] old);
        logic [31:0] m;
        m = old;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = data[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store FIFO with per-slot address match against a probe word address.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  sb_entry_t                push_entry,
    input  logic                     pop,
    input  logic [AW-3:0]            probe_waddr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output sb_entry_t                head,
    output sb_entry_t                entries [DEPTH],
    output logic [DEPTH-1:0]         match_vec
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    sb_entry_t     entries_q [DEPTH];
    sb_entry_t     entries_d [DEPTH];
    logic [PW-1:0] offset;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push) - CW'(pop);
        entries_d = entries_q;
        if (push) entries_d[wr_ptr_q] = push_entry;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        match_vec = '0;
        offset    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset       = PW'(i) - rd_ptr_q;
            match_vec[i] = ({1'b0, offset} < count_q) &&
                           (entries_q[i].waddr[AW-3:0] == probe_waddr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    assign count   = count_q;
    assign rd_ptr  = rd_ptr_q;
    assign head    = entries_q[rd_ptr_q];
    assign entries = entries_q;

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues CPU stores, drains them with read-merge-write, and answers load probes.
// Define STORE_BUFFER_FORWARD_EN to forward full-word data; otherwise any address hit stalls.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [3:0]    st_be,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_fwd_valid,
    output logic [31:0]   ld_fwd_data,
    output logic          ld_stall,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    input  logic          flush,
    output logic          empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CW-1:0]    count;
    logic [PW-1:0]    rd_ptr;
    sb_entry_t        head;
    sb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] match_vec;
    sb_entry_t        push_entry;
    logic             push, pop;

    sb_state_e        state_q, state_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             flush_q, flush_d;
    logic             flush_block;

    sb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .probe_waddr (ld_addr[AW-1:2]),
        .count       (count),
        .rd_ptr      (rd_ptr),
        .head        (head),
        .entries     (entries),
        .match_vec   (match_vec)
    );

    assign empty       = (count == '0) && (state_q == IDLE);
    assign flush_block = (flush || flush_q) && !empty;
    assign st_ready    = (count < CW'(DEPTH)) && !flush_block;
    assign push        = st_valid && st_ready && (st_be != 4'b0000);

    always_comb begin
        push_entry       = '0;
        push_entry.waddr = SB_WADDR_MAX'(st_addr[AW-1:2]);
        push_entry.data  = st_data;
        push_entry.be    = st_be;
        flush_d          = (flush || flush_q) && !empty;
    end

    // mem_addr is latched on leaving IDLE so mem_rdata refers to the head word during MERGE.
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    mem_addr_d = {head.waddr[AW-3:0], 2'b00};
                    if (head.be == 4'b1111) begin
                        mem_wdata_d = head.data;
                        state_d     = WRITE;
                    end else begin
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                mem_wdata_d = sb_merge(head.data, head.be, mem_rdata);
                state_d     = WRITE;
            end
            WRITE: begin
                pop     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            flush_q     <= flush_d;
        end
    end

    assign mem_we    = (state_q == WRITE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    logic          y_hit;
    sb_entry_t     y_entry;
    logic [PW-1:0] idx;
    logic          inflight;

    // Walk live slots oldest to youngest so the last hit wins.
    always_comb begin
        y_hit   = 1'b0;
        y_entry = '0;
        idx     = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (match_vec[idx]) begin
                y_hit   = 1'b1;
                y_entry = entries[idx];
            end
        end
    end

    assign inflight = (state_q != IDLE) && (mem_addr_q[AW-1:2] == ld_addr[AW-1:2]);

`ifdef STORE_BUFFER_FORWARD_EN
    assign ld_fwd_valid = y_hit && (y_entry.be == 4'b1111);
    assign ld_fwd_data  = ld_fwd_valid ? y_entry.data : '0;
    assign ld_stall     = (y_hit && (y_entry.be != 4'b1111)) || inflight;
`else
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = '0;
    assign ld_stall     = y_hit || inflight;
`endif

    logic unused_ok;
    assign unused_ok = ^{st_addr[1:0], ld_addr[1:0], y_entry, head.waddr};

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with a small word memory model.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [3:0]    st_be;
    logic [AW-1:0] ld_addr;
    logic          ld_fwd_valid;
    logic [31:0]   ld_fwd_data;
    logic          ld_stall;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          flush;
    logic          empty;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [64] = '{default: 32'h0};
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    int          nlog;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_be        (st_be),
        .ld_addr      (ld_addr),
        .ld_fwd_valid (ld_fwd_valid),
        .ld_fwd_data  (ld_fwd_data),
        .ld_stall     (ld_stall),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .flush        (flush),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_val;
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        st_valid = 1'b1;
        tick();
        st_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!empty && n < 50) begin
            tick();
            n++;
        end
        chk(tag, empty, 1);
    endtask

    initial begin
        rst_n = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_addr = '0; flush = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_empty", empty, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_fwd_valid", ld_fwd_valid, 0);
        chk("rst_stall", ld_stall, 0);
        chk("rst_st_ready", st_ready, 1);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Full-word store: write two edges after acceptance
        push(32'h10, 32'hDEADBEEF, 4'hF);
        chk("full_c1_we", mem_we, 0);
        chk("full_c1_empty", empty, 0);
        tick();
        chk("full_c2_we", mem_we, 1);
        chk("full_c2_addr", mem_addr, 32'h10);
        chk("full_c2_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        chk("full_c3_we", mem_we, 0);
        chk("full_c3_empty", empty, 1);
        chk("full_mem", mem[4], 32'hDEADBEEF);
        chk("full_hold_addr", mem_addr, 32'h10);

        // Partial store merges with memory word
        pre_idx = 6'd8; pre_val = 32'h11223344; pre_we = 1'b1;
        tick();
        pre_we = 1'b0;
        push(32'h20, 32'h000000AA, 4'b0001);
        chk("part_c1_we", mem_we, 0);
        tick();
        chk("part_c2_we", mem_we, 0);
        chk("part_c2_addr", mem_addr, 32'h20);
        tick();
        chk("part_c3_we", mem_we, 1);
        chk("part_c3_wdata", mem_wdata, 32'h112233AA);
        tick();
        chk("part_c4_we", mem_we, 0);
        chk("part_c4_empty", empty, 1);

        // Fill until full; retire cycle must not accept a push
        log_addr.delete(); log_data.delete();
        for (int k = 0; k < 6; k++) begin
            st_addr = 32'h40 + 32'(4 * k); st_data = 32'(k + 1); st_be = 4'hF; st_valid = 1'b1;
            chk($sformatf("fill_ready_%0d", k), st_ready, 1);
            tick();
        end
        st_addr = 32'h3C; st_data = 32'hBAD; st_be = 4'hF; st_valid = 1'b1;
        chk("full_ready_low", st_ready, 0);
        chk("full_retire_we", mem_we, 1);
        tick();
        st_valid = 1'b0;
        wait_empty("fill_drain");
        chk("fill_nwrites", log_addr.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("fill_addr_%0d", k), (k < log_addr.size()) ? log_addr[k] : 32'hFFFFFFFF,
                32'h40 + 32'(4 * k));
            chk($sformatf("fill_data_%0d", k), (k < log_data.size()) ? log_data[k] : 32'hFFFFFFFF,
                32'(k + 1));
        end
        chk("fill_no_bad", mem[15], 0);

        // Zero byte-enable store is accepted and dropped
        nlog = log_addr.size();
        st_addr = 32'h50; st_data = 32'h77; st_be = 4'h0; st_valid = 1'b1;
        chk("be0_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        chk("be0_empty", empty, 1);
        tick(); tick();
        chk("be0_no_write", log_addr.size(), nlog);

        // Forwarding: youngest full match
        push(32'h80, 32'h55, 4'hF);
        push(32'h30, 32'h1, 4'hF);
        push(32'h30, 32'h2, 4'hF);
        ld_addr = 32'h30; #1;
`ifdef STORE_BUFFER_FORWARD_EN
        chk("fwd_valid", ld_fwd_valid, 1);
        chk("fwd_data", ld_fwd_data, 32'h2);
        chk("fwd_stall", ld_stall, 0);
`else
        chk("fwd_valid", ld_fwd_valid, 0);
        chk("fwd_data", ld_fwd_data, 0);
        chk("fwd_stall", ld_stall, 1);
`endif
        ld_addr = 32'h32; #1;
`ifdef STORE_BUFFER_FORWARD_EN
        chk("fwd_lowbits_valid", ld_fwd_valid, 1);
`else
        chk("fwd_lowbits_stall", ld_stall, 1);
`endif
        ld_addr = 32'h34; #1;
        chk("miss_valid", ld_fwd_valid, 0);
        chk("miss_stall", ld_stall, 0);
        ld_addr = 32'h30;
        tick();
        chk("inflight_we", mem_we, 1);
        chk("inflight_stall", ld_stall, 1);
        ld_addr = '0;
        wait_empty("fwd_drain");
        chk("fwd_mem", mem[12], 32'h2);

        // Younger partial entry must stall
        push(32'h80, 32'h66, 4'hF);
        push(32'h30, 32'h10, 4'hF);
        push(32'h30, 32'hEE, 4'b0001);
        ld_addr = 32'h30; #1;
        chk("part_young_stall", ld_stall, 1);
        chk("part_young_valid", ld_fwd_valid, 0);
        ld_addr = '0;
        wait_empty("part_young_drain");
        chk("part_young_mem", mem[12], 32'h000000EE);

        // Flush blocks pushes until empty
        push(32'h60, 32'h1234, 4'hF);
        flush = 1'b1;
        st_addr = 32'h64; st_data = 32'hBEEF; st_be = 4'hF; st_valid = 1'b1;
        #1;
        chk("flush_ready_c1", st_ready, 0);
        tick();
        flush = 1'b0; #1;
        chk("flush_ready_held", st_ready, 0);
        tick();
        st_valid = 1'b0;
        chk("flush_done_empty", empty, 1);
        chk("flush_ready_after", st_ready, 1);
        chk("flush_mem", mem[24], 32'h1234);
        chk("flush_rejected", mem[25], 0);

        // Reset during WRITE aborts the drain
        push(32'h70, 32'hCAFE, 4'hF);
        push(32'h74, 32'hF00D, 4'hF);
        chk("rstmid_we_before", mem_we, 1);
        chk("rstmid_addr_before", mem_addr, 32'h70);
        nlog = log_addr.size();
        rst_n = 1'b0; #1;
        chk("rstmid_we", mem_we, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_addr", mem_addr, 0);
        chk("rstmid_wdata", mem_wdata, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("rstmid_no_writes", log_addr.size(), nlog);
        chk("rstmid_empty_after", empty, 1);
        chk("rstmid_mem70", mem[28], 0);
        chk("rstmid_mem74", mem[29], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
